// File: rtl/int_to_float_conv.sv
// int_to_float_conv
//   Iterative integer -> packed IEEE-754 converter (half / single / double).
//   It captures one operand, takes its magnitude, and normalises it with one
//   left shift per cycle. It then rounds to nearest-even and holds the result
//   until the consumer accepts it.
//
// Ports
//   clk_44        in   clock, rising edge
//   reset_44      in   asynchronous, active-low reset
//   in_valid_44   in   operand valid
//   in_ready_44   out  converter idle, operand can be accepted
//   int_in_44     in   [INT_WIDTH-1:0] integer operand
//   is_signed_44  in   1 = two's complement operand, 0 = unsigned
//   out_valid_44  out  result valid
//   out_ready_44  in   consumer accepts result
//   float_out_44  out  [REG_SIZE-1:0] packed {sign, exponent, fraction}
//   inexact_44    out  rounding discarded nonzero bits
//   overflow_44   out  result saturated to infinity
module int_to_float_conv #(
  parameter logic [1:0]  S         = 2'b00,
  parameter int unsigned INT_WIDTH = 16
) (
  input  logic                 clk_44,
  input  logic                 reset_44,
  input  logic                 in_valid_44,
  output logic                 in_ready_44,
  input  logic [INT_WIDTH-1:0] int_in_44,
  input  logic                 is_signed_44,
  output logic                 out_valid_44,
  input  logic                 out_ready_44,
  output logic [((S == 2'b00) ? 16 : (S == 2'b01) ? 32 : 64)-1:0] float_out_44,
  output logic                 inexact_44,
  output logic                 overflow_44
);

  localparam int unsigned REG_SIZE = (S == 2'b00) ? 16 : (S == 2'b01) ? 32 : 64;
  localparam int unsigned EXP_SIZE = (S == 2'b00) ? 5  : (S == 2'b01) ? 8  : 11;
  localparam int unsigned FRA_SIZE = (S == 2'b00) ? 10 : (S == 2'b01) ? 23 : 52;
  localparam int unsigned BIAS     = (S == 2'b00) ? 15 : (S == 2'b01) ? 127 : 1023;

  // The exponent register carries one spare bit so the rounding carry into
  // the all-ones code is visible. It is widened further when BIAS+INT_WIDTH
  // would not fit (half format with very wide integers).
  localparam int unsigned EXP_NEED = $clog2(BIAS + INT_WIDTH + 1);
  localparam int unsigned EXP_W    = (EXP_SIZE + 1 > EXP_NEED) ? EXP_SIZE + 1 : EXP_NEED;
  localparam int unsigned TAIL_W   = INT_WIDTH + FRA_SIZE + 1;

  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + INT_WIDTH - 1);
  localparam logic [EXP_W-1:0] EXP_MAX  = EXP_W'((1 << EXP_SIZE) - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  is_signed_q, is_signed_d;
  logic                  sgn_q, sgn_d;
  logic [INT_WIDTH-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]      exp_q, exp_d;
  logic [REG_SIZE-1:0]   float_q, float_d;
  logic                  inexact_q, inexact_d;
  logic                  overflow_q, overflow_d;

  // Rounding datapath, evaluated from the normalised magnitude.
  // Bits below the hidden bit, padded so that fraction, guard and sticky
  // always exist even when INT_WIDTH-1 < FRA_SIZE.
  logic [TAIL_W-1:0]     tail;
  logic [FRA_SIZE-1:0]   frac_raw;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [FRA_SIZE:0]     frac_inc;
  logic [EXP_W-1:0]      exp_rnd;
  logic                  neg;

  assign tail     = {mag_q[INT_WIDTH-2:0], {(FRA_SIZE + 2){1'b0}}};
  assign frac_raw = tail[TAIL_W-1 -: FRA_SIZE];
  assign guard    = tail[TAIL_W-1-FRA_SIZE];
  assign sticky   = |tail[TAIL_W-2-FRA_SIZE:0];
  assign round_up = guard & (sticky | frac_raw[0]);
  assign frac_inc = {1'b0, frac_raw} + (FRA_SIZE + 1)'(round_up);
  assign exp_rnd  = exp_q + EXP_W'(frac_inc[FRA_SIZE]);

  assign neg      = is_signed_q & mag_q[INT_WIDTH-1];

  always_comb begin
    state_d     = state_q;
    is_signed_d = is_signed_q;
    sgn_d       = sgn_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    float_d     = float_q;
    inexact_d   = inexact_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_44) begin
          mag_d       = int_in_44;
          is_signed_d = is_signed_44;
          state_d     = ST_ABS;
        end
      end

      ST_ABS: begin
        // The most negative value negates to 100..0, which is the correct
        // unsigned magnitude.
        sgn_d = neg;
        mag_d = neg ? -mag_q : mag_q;
        exp_d = EXP_INIT;
        // A zero operand skips NORM (it has no leading one). ROUND then
        // turns mag==0 into +0, which gives zero its two-cycle latency.
        state_d = (mag_q == '0) ? ST_ROUND : ST_NORM;
      end

      ST_NORM: begin
        if (mag_q[INT_WIDTH-1]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end

      ST_ROUND: begin
        if (mag_q == '0) begin
          float_d    = '0;
          inexact_d  = 1'b0;
          overflow_d = 1'b0;
        end else if (exp_rnd >= EXP_MAX) begin
          float_d    = {sgn_q, {EXP_SIZE{1'b1}}, {FRA_SIZE{1'b0}}};
          inexact_d  = guard | sticky;
          overflow_d = 1'b1;
        end else begin
          float_d    = {sgn_q, exp_rnd[EXP_SIZE-1:0], frac_inc[FRA_SIZE-1:0]};
          inexact_d  = guard | sticky;
          overflow_d = 1'b0;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready_44) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      state_q     <= ST_IDLE;
      is_signed_q <= 1'b0;
      sgn_q       <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      float_q     <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_signed_q <= is_signed_d;
      sgn_q       <= sgn_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      float_q     <= float_d;
      inexact_q   <= inexact_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready_44  = (state_q == ST_IDLE);
  assign out_valid_44 = (state_q == ST_DONE);
  assign float_out_44 = float_q;
  assign inexact_44   = inexact_q;
  assign overflow_44  = overflow_q;

endmodule

// File: tb/tb_int_to_float_conv.sv
// Scoreboard bench for int_to_float_conv: a half/16-bit instance (ch0) and a
// single/32-bit instance (ch1). Drivers push hand-computed expectations. A
// negedge monitor pops them, checks latency, and checks result stability
// during back-pressure.
module tb_int_to_float_conv;

  logic clk_44 = 1'b0;
  logic reset_44;

  logic        iv0, ir0, sg0, ov0, or0, ix0, of0;
  logic [15:0] in0, f0;
  logic        iv1, ir1, sg1, ov1, or1, ix1, of1;
  logic [31:0] in1, f1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] f;
    logic        ix;
    logic        of;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   busy[2];
  bit   idle_chk[2];

  int_to_float_conv #(.S(2'b00), .INT_WIDTH(16)) u_half (
    .clk_44(clk_44), .reset_44(reset_44),
    .in_valid_44(iv0), .in_ready_44(ir0), .int_in_44(in0), .is_signed_44(sg0),
    .out_valid_44(ov0), .out_ready_44(or0), .float_out_44(f0),
    .inexact_44(ix0), .overflow_44(of0)
  );

  int_to_float_conv #(.S(2'b01), .INT_WIDTH(32)) u_single (
    .clk_44(clk_44), .reset_44(reset_44),
    .in_valid_44(iv1), .in_ready_44(ir1), .int_in_44(in1), .is_signed_44(sg1),
    .out_valid_44(ov1), .out_ready_44(or1), .float_out_44(f1),
    .inexact_44(ix1), .overflow_44(of1)
  );

  always #5 clk_44 = ~clk_44;
  always @(posedge clk_44) cyc <= cyc + 1;

  task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %h expected %h (t=%0t)", name, ch, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk_44) begin
    if (reset_44) begin
      for (int ch = 0; ch < 2; ch++) begin
        logic        v, r, rdy, ix, of;
        logic [63:0] f;
        bit          empty;
        exp_t        e;
        if (ch == 0) begin
          v = ov0; r = or0; rdy = ir0; ix = ix0; of = of0; f = {48'b0, f0}; empty = (q0.size() == 0);
        end else begin
          v = ov1; r = or1; rdy = ir1; ix = ix1; of = of1; f = {32'b0, f1}; empty = (q1.size() == 0);
        end
        if (idle_chk[ch]) begin
          chk("idle_after_handshake", ch, {62'b0, rdy, v}, 64'b10);
          idle_chk[ch] = 1'b0;
        end
        if (v) begin
          if (!busy[ch]) begin
            if (empty) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid ch%0d: got out_valid=1 float=%h expected no result", ch, f);
            end else begin
              if (ch == 0) e = q0.pop_front();
              else         e = q1.pop_front();
              cur[ch]  = e;
              busy[ch] = 1'b1;
              chk("latency", ch, 64'(cyc - e.acc), 64'(e.lat));
            end
          end
          if (busy[ch]) begin
            chk("float_out", ch, f, cur[ch].f);
            chk("inexact", ch, {63'b0, ix}, {63'b0, cur[ch].ix});
            chk("overflow", ch, {63'b0, of}, {63'b0, cur[ch].of});
            chk("in_ready_in_done", ch, {63'b0, rdy}, 64'b0);
          end
          if (r) begin
            busy[ch]     = 1'b0;
            idle_chk[ch] = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_drain(input int ch);
    int n = 0;
    while ((ch == 0 ? (q0.size() != 0 || busy[0]) : (q1.size() != 0 || busy[1])) && n < 500) begin
      @(negedge clk_44);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout ch%0d: got no result after %0d cycles expected one", ch, n);
    end
  endtask

  task automatic issue(input int ch, input logic [63:0] val, input logic sg,
                       input logic [63:0] ef, input logic ex, input logic eo,
                       input int lat, input bit push, input bit wait_done);
    int   n = 0;
    exp_t e;
    @(negedge clk_44);
    if (ch == 0) begin in0 = val[15:0]; sg0 = sg; iv0 = 1'b1; end
    else         begin in1 = val[31:0]; sg1 = sg; iv1 = 1'b1; end
    while (!(ch == 0 ? ir0 : ir1) && n < 200) begin
      @(negedge clk_44);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout ch%0d: got in_ready=0 for %0d cycles expected 1", ch, n);
      iv0 = 1'b0;
      iv1 = 1'b0;
      return;
    end
    @(posedge clk_44);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    if (push) begin
      e.f = ef; e.ix = ex; e.of = eo; e.lat = lat; e.acc = cyc;
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
    if (wait_done) wait_drain(ch);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_44 = 1'b0;
    iv0 = 1'b0; in0 = '0; sg0 = 1'b0; or0 = 1'b1;
    iv1 = 1'b0; in1 = '0; sg1 = 1'b0; or1 = 1'b1;
    repeat (3) @(negedge clk_44);
    reset_44 = 1'b1;
    @(negedge clk_44);
    chk("reset_in_ready", 0, {63'b0, ir0}, 64'b1);
    chk("reset_in_ready", 1, {63'b0, ir1}, 64'b1);
    chk("reset_out_valid", 0, {63'b0, ov0}, 64'b0);
    chk("reset_out_valid", 1, {63'b0, ov1}, 64'b0);
    chk("reset_float", 0, {48'b0, f0}, 64'h0);
    chk("reset_float", 1, {32'b0, f1}, 64'h0);
    chk("reset_flags", 0, {62'b0, ix0, of0}, 64'b0);

    // half, 16-bit: value, signed, expected, inexact, overflow, latency
    issue(0, 64'h0001, 1'b1, 64'h3C00, 1'b0, 1'b0, 18, 1, 1);
    issue(0, 64'h0003, 1'b1, 64'h4200, 1'b0, 1'b0, 17, 1, 1);
    issue(0, 64'hFFF4, 1'b1, 64'hCA00, 1'b0, 1'b0, 15, 1, 1);
    issue(0, 64'h8000, 1'b1, 64'hF800, 1'b0, 1'b0,  3, 1, 1);
    issue(0, 64'h0000, 1'b1, 64'h0000, 1'b0, 1'b0,  2, 1, 1);
    issue(0, 64'hFFFF, 1'b1, 64'hBC00, 1'b0, 1'b0, 18, 1, 1);
    issue(0, 64'hFFFF, 1'b0, 64'h7C00, 1'b1, 1'b1,  3, 1, 1);
    issue(0, 64'd2049, 1'b1, 64'h6800, 1'b1, 1'b0,  7, 1, 1);
    issue(0, 64'd2051, 1'b1, 64'h6802, 1'b1, 1'b0,  7, 1, 1);
    issue(0, 64'd2047, 1'b1, 64'h67FF, 1'b0, 1'b0,  8, 1, 1);
    issue(0, 64'd65519, 1'b0, 64'h7BFF, 1'b1, 1'b0, 3, 1, 1);
    issue(0, 64'd65520, 1'b0, 64'h7C00, 1'b1, 1'b1, 3, 1, 1);

    // single, 32-bit
    issue(1, 64'h8000_0000, 1'b1, 64'hCF00_0000, 1'b0, 1'b0,  3, 1, 1);
    issue(1, 64'hFFFF_FFFF, 1'b0, 64'h4F80_0000, 1'b1, 1'b0,  3, 1, 1);
    issue(1, 64'd23,        1'b1, 64'h41B8_0000, 1'b0, 1'b0, 30, 1, 1);

    // Back-pressure: result held for 5 cycles while out_ready is low
    or0 = 1'b0;
    issue(0, 64'h0003, 1'b1, 64'h4200, 1'b0, 1'b0, 17, 1, 0);
    n = 0;
    while (!ov0 && n < 100) begin
      @(negedge clk_44);
      n++;
    end
    chk("bp_valid_seen", 0, {63'b0, ov0}, 64'b1);
    repeat (5) @(negedge clk_44);
    or0 = 1'b1;
    wait_drain(0);

    // Reset in the middle of NORM discards the operand
    issue(0, 64'h0001, 1'b1, 64'h0, 1'b0, 1'b0, 0, 0, 0);
    repeat (4) @(negedge clk_44);
    reset_44 = 1'b0;
    #2;
    chk("async_reset_in_ready", 0, {63'b0, ir0}, 64'b1);
    chk("async_reset_float", 0, {48'b0, f0}, 64'h0);
    repeat (2) @(negedge clk_44);
    reset_44 = 1'b1;
    repeat (25) @(negedge clk_44);
    chk("aborted_no_valid", 0, {63'b0, ov0}, 64'b0);
    chk("aborted_in_ready", 0, {63'b0, ir0}, 64'b1);
    issue(0, 64'hFFF4, 1'b1, 64'hCA00, 1'b0, 1'b0, 15, 1, 1);

    wait_drain(0);
    wait_drain(1);
    repeat (3) @(negedge clk_44);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
